// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: time-shares the board SPI bus (sck/mosi) between the preamp gain-write
// client and the ADC capture client, one transaction at a time. Ties are broken round-robin,
// every transaction is followed by a guard gap with sck held low, and a transaction that does
// not finish within TIMEOUT_CYCLES busy cycles is aborted.
// Build option: define ARB_STATS_EN to include the saturating grant/timeout counters;
// without it the counter outputs read zero and no counter logic is built.

module spi_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMR_W          = 8,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_amp_req,
    input  logic        i_adc_req,
    output logic        o_amp_start,
    output logic        o_adc_start,
    output logic        o_amp_gnt,
    output logic        o_adc_gnt,
    input  logic        i_amp_sck,
    input  logic        i_amp_mosi,
    input  logic        i_amp_cs_n,
    input  logic        i_adc_sck,
    input  logic        i_adc_mosi,
    input  logic        i_adc_done,
    output logic        o_spi_sck,
    output logic        o_spi_mosi,
    output logic        o_busy,
    output logic        o_bus_abort,
    output logic        o_timeout_err,
    input  logic        i_err_clr,
    output logic [15:0] o_amp_cnt,
    output logic [15:0] o_adc_cnt,
    output logic [15:0] o_to_cnt
);

    localparam logic [TMR_W-1:0] TimeoutLoad = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       GuardLoad   = 4'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStartAmp,
        StStartAdc,
        StBusyAmp,
        StBusyAdc,
        StGuard
    } state_t;

    state_t           r_state;
    logic             r_last_adc;   // 1: ADC was served last, so amp wins the next tie
    logic [TMR_W-1:0] r_timer;      // busy cycles left before the transaction is aborted
    logic [3:0]       r_guard;      // guard cycles left minus one
    logic             r_seen_low;   // preamp cs_n observed low during this busy phase
    logic             r_cs_prev;    // preamp cs_n one cycle ago, for rising-edge detection

    logic w_amp_done;
    logic w_adc_done;
    logic w_timer_zero;
    logic w_amp_first;
    logic w_sck;
    logic w_mosi;

    // A preamp transaction ends on a cs_n rising edge, but only after cs_n went low in this
    // busy phase; a stale high level at the start of the transaction is ignored.
    assign w_amp_done   = i_amp_cs_n & ~r_cs_prev & r_seen_low;
    assign w_adc_done   = i_adc_done;
    assign w_timer_zero = (r_timer == '0);
    assign w_amp_first  = i_amp_req & (~i_adc_req | r_last_adc);

    // Arbitration FSM with registered start/grant/busy/abort/error outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_last_adc    <= 1'b1;
            r_timer       <= '0;
            r_guard       <= '0;
            r_seen_low    <= 1'b0;
            o_amp_start   <= 1'b0;
            o_adc_start   <= 1'b0;
            o_amp_gnt     <= 1'b0;
            o_adc_gnt     <= 1'b0;
            o_busy        <= 1'b0;
            o_bus_abort   <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_amp_start <= 1'b0;
            o_adc_start <= 1'b0;
            o_bus_abort <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (i_err_clr) begin
                o_timeout_err <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_amp_first) begin
                        r_state     <= StStartAmp;
                        o_amp_start <= 1'b1;
                        o_amp_gnt   <= 1'b1;
                        o_busy      <= 1'b1;
                        r_timer     <= TimeoutLoad;
                        r_seen_low  <= 1'b0;
                    end else if (i_adc_req) begin
                        r_state     <= StStartAdc;
                        o_adc_start <= 1'b1;
                        o_adc_gnt   <= 1'b1;
                        o_busy      <= 1'b1;
                        r_timer     <= TimeoutLoad;
                        r_seen_low  <= 1'b0;
                    end
                end

                // The start cycle counts against the timeout budget.
                StStartAmp: begin
                    r_state <= StBusyAmp;
                    r_timer <= r_timer - 1'b1;
                end

                StStartAdc: begin
                    r_state <= StBusyAdc;
                    r_timer <= r_timer - 1'b1;
                end

                StBusyAmp: begin
                    if (!i_amp_cs_n) begin
                        r_seen_low <= 1'b1;
                    end
                    if (w_amp_done || w_timer_zero) begin
                        r_state     <= StGuard;
                        r_guard     <= GuardLoad;
                        r_last_adc  <= 1'b0;
                        o_amp_gnt   <= 1'b0;
                        // Completion on the last allowed cycle is not a timeout.
                        if (!w_amp_done) begin
                            o_bus_abort   <= 1'b1;
                            o_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                StBusyAdc: begin
                    if (w_adc_done || w_timer_zero) begin
                        r_state     <= StGuard;
                        r_guard     <= GuardLoad;
                        r_last_adc  <= 1'b1;
                        o_adc_gnt   <= 1'b0;
                        if (!w_adc_done) begin
                            o_bus_abort   <= 1'b1;
                            o_timeout_err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                StGuard: begin
                    if (r_guard == 4'd0) begin
                        r_state <= StIdle;
                        o_busy  <= 1'b0;
                    end else begin
                        r_guard <= r_guard - 4'd1;
                    end
                end

                default: begin
                    r_state   <= StIdle;
                    o_amp_gnt <= 1'b0;
                    o_adc_gnt <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Track preamp cs_n history for done detection
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cs_prev <= 1'b1;
        end else begin
            r_cs_prev <= i_amp_cs_n;
        end
    end

    // Route the owning client's sck/mosi to the bus; bus idles low outside busy phases
    always_comb begin
        w_sck  = 1'b0;
        w_mosi = 1'b0;
        if (r_state == StBusyAmp) begin
            w_sck  = i_amp_sck;
            w_mosi = i_amp_mosi;
        end else if (r_state == StBusyAdc) begin
            w_sck  = i_adc_sck;
            w_mosi = i_adc_mosi;
        end
    end

    assign o_spi_sck  = w_sck;
    assign o_spi_mosi = w_mosi;

`ifdef ARB_STATS_EN
    logic [15:0] r_amp_cnt;
    logic [15:0] r_adc_cnt;
    logic [15:0] r_to_cnt;

    // Saturating grant and timeout statistics, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_amp_cnt <= 16'h0;
            r_adc_cnt <= 16'h0;
            r_to_cnt  <= 16'h0;
        end else begin
            if (r_state == StStartAmp && r_amp_cnt != 16'hFFFF) begin
                r_amp_cnt <= r_amp_cnt + 16'd1;
            end
            if (r_state == StStartAdc && r_adc_cnt != 16'hFFFF) begin
                r_adc_cnt <= r_adc_cnt + 16'd1;
            end
            if (o_bus_abort && r_to_cnt != 16'hFFFF) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign o_amp_cnt = r_amp_cnt;
    assign o_adc_cnt = r_adc_cnt;
    assign o_to_cnt  = r_to_cnt;
`else
    assign o_amp_cnt = 16'h0;
    assign o_adc_cnt = 16'h0;
    assign o_to_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: a transaction-level reference model predicts
// every output each cycle, directed scenarios pin exact latencies, then random traffic runs.

module tb_spi_bus_arbiter;

    localparam int TIMEOUT = 255;
    localparam int GUARD   = 2;

    logic        clk;
    logic        reset_n;
    logic        amp_req, adc_req;
    logic        amp_start, adc_start, amp_gnt, adc_gnt;
    logic        amp_sck, amp_mosi, amp_cs_n;
    logic        adc_sck, adc_mosi, adc_done;
    logic        spi_sck, spi_mosi, busy, bus_abort, timeout_err, err_clr;
    logic [15:0] amp_cnt, adc_cnt, to_cnt;

    int checks = 0;
    int errors = 0;

    spi_bus_arbiter #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .TMR_W         (8),
        .GUARD_CYCLES  (GUARD)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_amp_req    (amp_req),
        .i_adc_req    (adc_req),
        .o_amp_start  (amp_start),
        .o_adc_start  (adc_start),
        .o_amp_gnt    (amp_gnt),
        .o_adc_gnt    (adc_gnt),
        .i_amp_sck    (amp_sck),
        .i_amp_mosi   (amp_mosi),
        .i_amp_cs_n   (amp_cs_n),
        .i_adc_sck    (adc_sck),
        .i_adc_mosi   (adc_mosi),
        .i_adc_done   (adc_done),
        .o_spi_sck    (spi_sck),
        .o_spi_mosi   (spi_mosi),
        .o_busy       (busy),
        .o_bus_abort  (bus_abort),
        .o_timeout_err(timeout_err),
        .i_err_clr    (err_clr),
        .o_amp_cnt    (amp_cnt),
        .o_adc_cnt    (adc_cnt),
        .o_to_cnt     (to_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within cycle bound at %0t", name, $time);
    endtask

    // ---------------- client models (stimulus only) ----------------
    int amp_len = 18, adc_len = 10;
    bit amp_hang = 0, adc_hang = 0;
    int amp_left = 0, adc_left = 0;

    initial begin
        amp_cs_n = 1'b1; amp_sck = 1'b0; amp_mosi = 1'b0;
        adc_sck = 1'b0; adc_mosi = 1'b0; adc_done = 1'b0;
    end

    always begin
        @(posedge clk);
        #1;
        if (amp_left > 0) begin
            amp_left--;
            amp_cs_n = 1'b0;
        end else begin
            amp_cs_n = 1'b1;
        end
        amp_sck  = 1'($urandom_range(0, 1));
        amp_mosi = 1'($urandom_range(0, 1));
        adc_done = 1'b0;
        if (adc_left > 0) begin
            adc_left--;
            if (adc_left == 0) adc_done = 1'b1;
        end
        adc_sck  = 1'($urandom_range(0, 1));
        adc_mosi = 1'($urandom_range(0, 1));
        if (bus_abort) begin
            amp_left = 0;
            adc_left = 0;
        end
        if (amp_start) amp_left = amp_hang ? 100000 : amp_len;
        if (adc_start) adc_left = adc_hang ? 100000 : adc_len;
    end

    // ---------------- transaction-level reference model ----------------
    // m_owner: 0 none, 1 amp, 2 adc. m_since: cycles since the start pulse (0 = start cycle).
    int m_owner = 0, m_since = 0, m_guard = 0;
    bit m_last_adc = 1, m_abort = 0, m_err = 0, m_cs_last = 1, m_valid = 0, m_done = 0;
    int m_amp_cnt = 0, m_adc_cnt = 0, m_to_cnt = 0;

    always begin
        @(posedge clk);
        if (!reset_n) begin
            m_owner = 0; m_since = 0; m_guard = 0; m_last_adc = 1;
            m_abort = 0; m_err = 0; m_cs_last = 1;
            m_amp_cnt = 0; m_adc_cnt = 0; m_to_cnt = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_abort) m_to_cnt++;
            m_abort = 0;
            if (err_clr) m_err = 0;
            if (m_guard > 0) begin
                m_guard--;
            end else if (m_owner == 0) begin
                if (amp_req && (!adc_req || m_last_adc)) begin
                    m_owner = 1; m_since = 0;
                end else if (adc_req) begin
                    m_owner = 2; m_since = 0;
                end
            end else if (m_since == 0) begin
                m_since = 1;
                if (m_owner == 1) m_amp_cnt++; else m_adc_cnt++;
            end else begin
                if (m_owner == 1) m_done = (m_since >= 2) && amp_cs_n && !m_cs_last;
                else              m_done = adc_done;
                if (m_done || m_since >= TIMEOUT) begin
                    if (!m_done) begin
                        m_abort = 1;
                        m_err   = 1;
                    end
                    m_last_adc = (m_owner == 2);
                    m_owner    = 0;
                    m_guard    = GUARD;
                end else begin
                    m_since++;
                end
            end
            m_cs_last = amp_cs_n;
        end
    end

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Per-cycle comparison of every output against the model
    always begin
        logic e_sck, e_mosi;
        @(negedge clk);
        if (m_valid) begin
            e_sck = 1'b0; e_mosi = 1'b0;
            if (m_owner == 1 && m_since >= 1) begin e_sck = amp_sck; e_mosi = amp_mosi; end
            if (m_owner == 2 && m_since >= 1) begin e_sck = adc_sck; e_mosi = adc_mosi; end
            chk("amp_start", 32'(amp_start), 32'(m_owner == 1 && m_since == 0));
            chk("adc_start", 32'(adc_start), 32'(m_owner == 2 && m_since == 0));
            chk("amp_gnt", 32'(amp_gnt), 32'(m_owner == 1));
            chk("adc_gnt", 32'(adc_gnt), 32'(m_owner == 2));
            chk("busy", 32'(busy), 32'(m_owner != 0 || m_guard > 0));
            chk("bus_abort", 32'(bus_abort), 32'(m_abort));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
            chk("spi_sck", 32'(spi_sck), 32'(e_sck));
            chk("spi_mosi", 32'(spi_mosi), 32'(e_mosi));
            if (m_owner == 0 && m_guard == 0) begin
`ifdef ARB_STATS_EN
                chk("amp_cnt", 32'(amp_cnt), 32'(sat16(m_amp_cnt)));
                chk("adc_cnt", 32'(adc_cnt), 32'(sat16(m_adc_cnt)));
                chk("to_cnt", 32'(to_cnt), 32'(sat16(m_to_cnt)));
`else
                chk("amp_cnt", 32'(amp_cnt), 32'h0);
                chk("adc_cnt", 32'(adc_cnt), 32'h0);
                chk("to_cnt", 32'(to_cnt), 32'h0);
`endif
            end
        end
    end

    // ---------------- directed sequencing helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int who);
        who = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (amp_start) begin who = 1; break; end
            if (adc_start) begin who = 2; break; end
        end
        if (who == 0) bound_fail("wait_start");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        if (busy) bound_fail("wait_idle");
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic run_txn(input bit amp, output int who);
        amp_req = amp;
        adc_req = !amp;
        wait_start(who);
        amp_req = 1'b0;
        adc_req = 1'b0;
        wait_idle();
    endtask

    int who, n;

    initial begin
        reset_n = 1'b0; amp_req = 1'b0; adc_req = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_outputs",
            32'({amp_start, adc_start, amp_gnt, adc_gnt, busy, bus_abort, timeout_err,
                 spi_sck, spi_mosi}), 32'h0);
        chk("rst_counters", 32'(amp_cnt | adc_cnt | to_cnt), 32'h0);
        reset_n = 1'b1;
        tick();

        // 1: single amp request, preamp holds cs_n low 18 cycles
        amp_len = 18;
        amp_req = 1'b1;
        tick();
        chk("t1_amp_start", 32'(amp_start), 32'h1);
        chk("t1_amp_gnt", 32'(amp_gnt), 32'h1);
        amp_req = 1'b0;
        n = 0;
        while (busy && n < 500) begin tick(); n++; end
        // start + 18 low + rise cycle + 2 guard -> idle 22 cycles after the start pulse
        chk("t1_busy_len", 32'(n), 32'd22);

        // 2: simultaneous requests after reset alternate amp, adc, amp, adc
        do_reset();
        for (int k = 0; k < 4; k++) begin
            amp_req = 1'b1; adc_req = 1'b1;
            wait_start(who);
            amp_req = 1'b0; adc_req = 1'b0;
            chk("t2_round_robin", 32'(who), (k % 2 == 0) ? 32'd1 : 32'd2);
            wait_idle();
        end

        // 3: hung ADC transaction is aborted 256 cycles after its start pulse
        adc_hang = 1;
        adc_req = 1'b1;
        wait_start(who);
        adc_req = 1'b0;
        chk("t3_who", 32'(who), 32'd2);
        n = 0;
        while (!bus_abort && n < 400) begin tick(); n++; end
        chk("t3_abort_latency", 32'(n), 32'd256);
        chk("t3_err_set", 32'(timeout_err), 32'h1);
        tick();
        chk("t3_abort_one_cycle", 32'(bus_abort), 32'h0);
        wait_idle();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(timeout_err), 32'h0);
        adc_req = 1'b1;
        wait_start(who);
        adc_req = 1'b0;
        repeat (255) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_abort2", 32'(bus_abort), 32'h1);
        chk("t3_set_wins", 32'(timeout_err), 32'h1);
        adc_hang = 0;
        wait_idle();

        // 5: ADC done on the final allowed cycle is a completion, not an abort
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        adc_len = 255;
        adc_req = 1'b1;
        wait_start(who);
        adc_req = 1'b0;
        repeat (256) tick();
        chk("t5_no_abort", 32'(bus_abort), 32'h0);
        chk("t5_err_clear", 32'(timeout_err), 32'h0);
        chk("t5_guard_busy", 32'(busy), 32'h1);
        chk("t5_guard_gnt", 32'(adc_gnt), 32'h0);
        adc_len = 10;
        wait_idle();

        // 4: reset during an amp busy phase, then a tie still goes to amp
        amp_req = 1'b1;
        wait_start(who);
        amp_req = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        chk("t4_reset_outputs",
            32'({amp_start, adc_start, amp_gnt, adc_gnt, busy, bus_abort, timeout_err,
                 spi_sck, spi_mosi}), 32'h0);
        reset_n = 1'b1;
        amp_req = 1'b1; adc_req = 1'b1;
        wait_start(who);
        amp_req = 1'b0; adc_req = 1'b0;
        chk("t4_tie_amp", 32'(who), 32'd1);
        wait_idle();

        // 6: statistics: 3 amp, 2 adc (one of which times out)
        do_reset();
        for (int k = 0; k < 3; k++) run_txn(1'b1, who);
        run_txn(1'b0, who);
        adc_hang = 1;
        run_txn(1'b0, who);
        adc_hang = 0;
        tick();
`ifdef ARB_STATS_EN
        chk("t6_amp_cnt", 32'(amp_cnt), 32'd3);
        chk("t6_adc_cnt", 32'(adc_cnt), 32'd2);
        chk("t6_to_cnt", 32'(to_cnt), 32'd1);
`else
        chk("t6_amp_cnt", 32'(amp_cnt), 32'd0);
        chk("t6_adc_cnt", 32'(adc_cnt), 32'd0);
        chk("t6_to_cnt", 32'(to_cnt), 32'd0);
`endif

        // Random traffic against the model
        for (int c = 0; c < 6000; c++) begin
            amp_req  = ($urandom_range(0, 3) == 0);
            adc_req  = ($urandom_range(0, 3) == 0);
            err_clr  = ($urandom_range(0, 15) == 0);
            amp_len  = $urandom_range(0, 25);
            adc_len  = $urandom_range(1, 40);
            amp_hang = ($urandom_range(0, 49) == 0);
            adc_hang = ($urandom_range(0, 49) == 0);
            reset_n  = ($urandom_range(0, 299) != 0);
            tick();
        end
        amp_req = 1'b0; adc_req = 1'b0; err_clr = 1'b0; reset_n = 1'b1;
        amp_hang = 0; adc_hang = 0;
        wait_idle();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
